instr_cache: RTL and testbench

INSTR_CACHE -- requirements
Module: instr_cache

---
 rtl/instr_cache_pkg.sv | 25 ++
 rtl/icache_array.sv | 51 +++++
 rtl/instr_cache.sv | 132 +++++++++++++
 tb/tb_instr_cache.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package instr_cache_pkg;

  // Refill controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    COMMIT = 2'd2
  } icache_state_t;

  // Returned on any fetch that does not hit (addi x0, x0, 0)
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Field widths for the default geometry (16 sets x 4 words)
  localparam int OFF_W = 2;
  localparam int IDX_W = 4;
  localparam int TAG_W = 24;

  // Backing-memory word request
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } mem_req_t;

endpackage

// File: rtl/icache_array.sv
// Data, tag and valid storage: combinational read, one synchronous write port.
// Valid bits are flops so flush and reset clear every line in one cycle.
module icache_array #(
  parameter int NUM_SETS       = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = 4,
  parameter int OFF_W          = 2,
  parameter int TAG_W          = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic [31:0]      rd_data,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  input  logic             wr_data_en,
  input  logic             wr_line_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             flush
);

  logic [NUM_SETS-1:0][WORDS_PER_LINE-1:0][31:0] data_q;
  logic [NUM_SETS-1:0][TAG_W-1:0]                tag_q;
  logic [NUM_SETS-1:0]                           valid_q;

  assign rd_data  = data_q[rd_idx][rd_off];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

  // Data words land one beat at a time; tag is written when the line commits
  always_ff @(posedge clk) begin
    if (wr_data_en) data_q[wr_idx][wr_off] <= wr_data;
    if (wr_line_en) tag_q[wr_idx] <= wr_tag;
  end

  // Valid bits: flush wipes all lines, a commit then sets or clears its own line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (flush) valid_q <= '0;
      if (wr_line_en) valid_q[wr_idx] <= wr_valid;
    end
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with a word-by-word refill FSM.
// Hits return data in the same cycle; a miss stalls fetch until the line commits.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int NUM_SETS       = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] addr,
  input  logic        flush_i,
  output logic [31:0] rd_o,
  output logic        instr_miss_f_o,
  output logic        instr_cache_rep_en_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 30 - OW - IW;
  localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS_PER_LINE - 1);

  icache_state_t state_q, state_d;

  // Line address of the fill in flight (fill_base without its zero offset bits)
  logic [29-OW:0] fill_line;
  logic [OW-1:0]  beat_cnt;
  logic           abort_q;

  logic [OW-1:0]  off;
  logic [IW-1:0]  idx;
  logic [TW-1:0]  tag;
  logic [1:0]     unused_addr_lsb;

  logic [31:0]    rd_data;
  logic [TW-1:0]  rd_tag;
  logic           rd_valid;
  logic           hit;

  logic           wr_data_en;
  logic           wr_line_en;
  logic           wr_valid;
  mem_req_t       mem;

  assign off             = addr[2 +: OW];
  assign idx             = addr[2+OW +: IW];
  assign tag             = addr[31 -: TW];
  assign unused_addr_lsb = addr[1:0];

  assign wr_data_en = (state_q == REFILL) && mem_ack_i;
  assign wr_line_en = (state_q == COMMIT);
  // A flush seen anywhere during the fill (or on the commit cycle) keeps the line invalid
  assign wr_valid   = !(abort_q || flush_i);

  icache_array #(
    .NUM_SETS      (NUM_SETS),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .IDX_W         (IW),
    .OFF_W         (OW),
    .TAG_W         (TW)
  ) u_array (
    .clk       (clk_i),
    .rst       (reset_i),
    .rd_idx    (idx),
    .rd_off    (off),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_data_en(wr_data_en),
    .wr_line_en(wr_line_en),
    .wr_idx    (fill_line[IW-1:0]),
    .wr_off    (beat_cnt),
    .wr_data   (mem_rdata_i),
    .wr_tag    (fill_line[29-OW -: TW]),
    .wr_valid  (wr_valid),
    .flush     (flush_i)
  );

  assign hit  = rd_valid && (rd_tag == tag);
  assign rd_o = hit ? rd_data : NOP;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: flush in IDLE suppresses the refill for that cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!hit && !flush_i) state_d = REFILL;
      REFILL:  if (mem_ack_i && beat_cnt == LAST_BEAT) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops the request immediately
  always_comb begin
    mem.req              = (state_q == REFILL);
    mem.addr             = mem.req ? {fill_line, beat_cnt, 2'b00} : 32'h0;
    instr_cache_rep_en_o = (state_q == COMMIT);
    instr_miss_f_o       = !hit || (state_q != IDLE);
  end

  assign mem_req_o  = mem.req;
  assign mem_addr_o = mem.addr;

  // Fill bookkeeping: latch the line on miss, count beats, remember any flush
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fill_line <= '0;
      beat_cnt  <= '0;
      abort_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d == REFILL) begin
        fill_line <= addr[31:2+OW];
        beat_cnt  <= '0;
        abort_q   <= 1'b0;
      end else if (wr_data_en) begin
        beat_cnt  <= beat_cnt + 1'b1;
      end
      if (flush_i && state_q != IDLE) abort_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: a memory model answers refill requests
// and a queue of expected beat addresses is checked as each ack is issued.
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] addr;
  logic        flush_i;
  logic [31:0] rd_o;
  logic        instr_miss_f_o;
  logic        instr_cache_rep_en_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int mem_delay = 0;
  int wait_cnt = 0;
  int beats = 0;
  bit hold_valid = 0;
  logic [31:0] hold_addr = 0;
  bit force_ack = 0;

  instr_cache dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .addr                (addr),
    .flush_i             (flush_i),
    .rd_o                (rd_o),
    .instr_miss_f_o      (instr_miss_f_o),
    .instr_cache_rep_en_o(instr_cache_rep_en_o),
    .mem_req_o           (mem_req_o),
    .mem_addr_o          (mem_addr_o),
    .mem_ack_i           (mem_ack_i),
    .mem_rdata_i         (mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE ^ a[31:16], a[15:0] ^ 16'h0F00};
  endfunction

  // One clock: memory model decides ack at negedge, then advance past posedge
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    if (mem_req_o) begin
      if (hold_valid) begin
        checks++;
        if (mem_addr_o !== hold_addr) begin
          errors++; $display("FAIL addr_stable: got %h expected %h", mem_addr_o, hold_addr);
        end
      end
      if (wait_cnt >= mem_delay) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_word(mem_addr_o);
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL beat_addr: got %h expected none", mem_addr_o);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr_o !== e) begin
            errors++; $display("FAIL beat_addr: got %h expected %h", mem_addr_o, e);
          end
        end
        wait_cnt = 0; hold_valid = 0; beats++;
      end else begin
        wait_cnt++; hold_valid = 1; hold_addr = mem_addr_o;
      end
    end else begin
      wait_cnt = 0; hold_valid = 0;
      checks++;
      if (mem_addr_o !== 32'h0) begin
        errors++; $display("FAIL addr_idle_zero: got %h expected 0", mem_addr_o);
      end
    end
    if (force_ack) begin mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
  endtask

  // Drive a full refill of line a; cyc counts REFILL+COMMIT cycles, pulses counts rep_en
  task automatic run_fill(input logic [31:0] a, input int dly, input int flush_at,
                          input int switch_at, input logic [31:0] switch_addr,
                          output int cyc, output int pulses);
    logic [31:0] base;
    bit done, fl_done, sw_done;
    addr = a; mem_delay = dly; beats = 0; cyc = 0; pulses = 0;
    done = 0; fl_done = 0; sw_done = 0;
    base = {a[31:4], 4'h0};
    for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(4 * i));
    for (int n = 0; n < 400 && !done; n++) begin
      flush_i = 1'b0;
      if (mem_req_o && !fl_done && beats == flush_at) begin flush_i = 1'b1; fl_done = 1; end
      if (mem_req_o && !sw_done && beats == switch_at) begin addr = switch_addr; sw_done = 1; end
      if (mem_req_o || instr_cache_rep_en_o) cyc++;
      if (instr_cache_rep_en_o) begin pulses++; done = 1; end
      tick();
    end
    flush_i = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL fill_timeout: got no commit expected commit for %h", a); end
    if (instr_cache_rep_en_o) pulses++;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL beats_left: got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic flush_all();
    flush_i = 1'b1; tick(); flush_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; addr = 32'h0; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || instr_cache_rep_en_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got req=%b addr=%h rep=%b expected 0 0 0",
                         mem_req_o, mem_addr_o, instr_cache_rep_en_o);
    end
    tick(); tick();
    checks++;
    if (instr_miss_f_o !== 1'b1 || rd_o !== NOP_W) begin
      errors++; $display("FAIL reset_miss: got miss=%b rd=%h expected 1 %h", instr_miss_f_o, rd_o, NOP_W);
    end
  endtask

  task automatic test_cold_miss();
    int cyc, pulses;
    addr = 32'h100; reset_i = 1'b0; #1;
    checks++;
    if (instr_miss_f_o !== 1'b1 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL cold_first: got miss=%b req=%b expected 1 0", instr_miss_f_o, mem_req_o);
    end
    run_fill(32'h100, 0, -1, -1, 32'h0, cyc, pulses);
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL cold_cycles: got %0d expected 5", cyc); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL cold_pulses: got %0d expected 1", pulses); end
    checks++;
    if (instr_miss_f_o !== 1'b0 || rd_o !== mem_word(32'h100)) begin
      errors++; $display("FAIL cold_hit: got miss=%b rd=%h expected 0 %h", instr_miss_f_o, rd_o, mem_word(32'h100));
    end
    addr = 32'h10C; #1;
    checks++;
    if (instr_miss_f_o !== 1'b0 || rd_o !== mem_word(32'h10C)) begin
      errors++; $display("FAIL cold_word3: got miss=%b rd=%h expected 0 %h", instr_miss_f_o, rd_o, mem_word(32'h10C));
    end
  endtask

  task automatic test_back_pressure();
    int cyc, pulses;
    flush_all();
    run_fill(32'h100, 3, -1, -1, 32'h0, cyc, pulses);
    checks++;
    if (cyc != 17) begin errors++; $display("FAIL bp_cycles: got %0d expected 17", cyc); end
    checks++;
    if (pulses != 1 || rd_o !== mem_word(32'h100)) begin
      errors++; $display("FAIL bp_hit: got pulses=%0d rd=%h expected 1 %h", pulses, rd_o, mem_word(32'h100));
    end
  endtask

  task automatic test_conflict();
    int cyc, pulses;
    run_fill(32'h200, 0, -1, -1, 32'h0, cyc, pulses);
    addr = 32'h208; #1;
    checks++;
    if (instr_miss_f_o !== 1'b0 || rd_o !== mem_word(32'h208)) begin
      errors++; $display("FAIL conflict_hit: got miss=%b rd=%h expected 0 %h", instr_miss_f_o, rd_o, mem_word(32'h208));
    end
    addr = 32'h100; #1;
    checks++;
    if (instr_miss_f_o !== 1'b1 || rd_o !== NOP_W) begin
      errors++; $display("FAIL conflict_evict: got miss=%b rd=%h expected 1 %h", instr_miss_f_o, rd_o, NOP_W);
    end
    run_fill(32'h100, 0, -1, -1, 32'h0, cyc, pulses);
  endtask

  task automatic test_flush_idle();
    int cyc, pulses;
    addr = 32'h200; flush_i = 1'b1; #1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b0) begin errors++; $display("FAIL flush_idle_norefill: got req=%b expected 0", mem_req_o); end
    addr = 32'h100; #1;
    checks++;
    if (instr_miss_f_o !== 1'b1) begin errors++; $display("FAIL flush_idle_inval: got miss=%b expected 1", instr_miss_f_o); end
    run_fill(32'h100, 0, -1, -1, 32'h0, cyc, pulses);
  endtask

  task automatic test_flush_mid_refill();
    int cyc, pulses;
    flush_all();
    run_fill(32'h140, 1, 2, -1, 32'h0, cyc, pulses);
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL flush_mid_pulse: got %0d expected 1", pulses); end
    checks++;
    if (instr_miss_f_o !== 1'b1 || rd_o !== NOP_W) begin
      errors++; $display("FAIL flush_mid_miss: got miss=%b rd=%h expected 1 %h", instr_miss_f_o, rd_o, NOP_W);
    end
    run_fill(32'h140, 0, -1, -1, 32'h0, cyc, pulses);
  endtask

  task automatic test_reset_mid_refill();
    int cyc, pulses;
    flush_all();
    addr = 32'h100; mem_delay = 0; beats = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    tick(); tick();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104) begin
      errors++; $display("FAIL rst_mid_beat1: got req=%b addr=%h expected 1 00000104", mem_req_o, mem_addr_o);
    end
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      errors++; $display("FAIL rst_mid_drop: got req=%b addr=%h expected 0 0", mem_req_o, mem_addr_o);
    end
    exp_q.delete();
    force_ack = 1;
    tick();
    reset_i = 1'b0; #1;
    tick();
    force_ack = 0;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      errors++; $display("FAIL rst_mid_restart: got req=%b addr=%h expected 1 00000100", mem_req_o, mem_addr_o);
    end
    run_fill(32'h100, 0, -1, -1, 32'h0, cyc, pulses);
    checks++;
    if (instr_miss_f_o !== 1'b0 || rd_o !== mem_word(32'h100)) begin
      errors++; $display("FAIL rst_mid_hit: got miss=%b rd=%h expected 0 %h", instr_miss_f_o, rd_o, mem_word(32'h100));
    end
  endtask

  task automatic test_addr_change();
    int cyc, pulses;
    flush_all();
    run_fill(32'h100, 0, -1, 1, 32'h300, cyc, pulses);
    addr = 32'h104; #1;
    checks++;
    if (instr_miss_f_o !== 1'b0 || rd_o !== mem_word(32'h104)) begin
      errors++; $display("FAIL switch_commit: got miss=%b rd=%h expected 0 %h", instr_miss_f_o, rd_o, mem_word(32'h104));
    end
    addr = 32'h300; #1;
    tick();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin
      errors++; $display("FAIL switch_refill: got req=%b addr=%h expected 1 00000300", mem_req_o, mem_addr_o);
    end
    run_fill(32'h300, 0, -1, -1, 32'h0, cyc, pulses);
    addr = 32'h308; #1;
    checks++;
    if (instr_miss_f_o !== 1'b0 || rd_o !== mem_word(32'h308)) begin
      errors++; $display("FAIL switch_hit: got miss=%b rd=%h expected 0 %h", instr_miss_f_o, rd_o, mem_word(32'h308));
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_pressure();
    test_conflict();
    test_flush_idle();
    test_flush_mid_refill();
    test_reset_mid_refill();
    test_addr_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
